branch_operand_resolver: RTL

- Parametrised successor to the ID-stage branch forwarding logic of the 5-stage RISC-V pipeline.
- Resolves NUM_SRC branch source operands in ID by forwarding from EX/MEM and MEM/WB, or from the register file when no producer is in flight.
- Adds a registered hazard FSM that stalls IF/ID (and bubbles ID/EX) while a producer's result is not yet forwardable: ALU result still in EX, or load result not yet at MEM/WB.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/branch_fwd_mux.sv | 73 +++++++
 rtl/branch_operand_resolver.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the ID-stage branch operand forwarding and hazard logic.
// Holds the forward-select and hold-FSM encodings, the hazard class ordering
// and a helper that picks the worse of two hazard classes.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_EXMEM,
        FWD_MEMWB
    } fwd_sel_e;

    typedef enum logic {
        IDLE,
        HOLD
    } hold_state_e;

    // Ordered so that a larger value means a longer required stall.
    typedef enum logic [1:0] {
        HZ_NONE,
        HZ_ONE,
        HZ_TWO
    } hz_class_e;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned HOLD_W   = 2;

    function automatic hz_class_e hz_max(input hz_class_e a, input hz_class_e b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/branch_fwd_mux.sv
// Per-source branch operand select and hazard classification.
// Ports:
//   branch_valid         - ID holds a branch; matches are ignored when low
//   rs, rf_data          - source register address and register-file data
//   idex_*/exmem_*/memwb_* - producer controls and destinations per stage
//   exmem_alu_result, wb_data - forwardable results
//   data_c               - resolved operand (combinational)
//   hz_c                 - stall class needed for this source (combinational)
module branch_fwd_mux
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned REG_W = 5
) (
    input  logic             branch_valid,
    input  logic [REG_W-1:0] rs,
    input  logic [XLEN-1:0]  rf_data,
    input  logic             idex_regwrite,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rd,
    input  logic             exmem_regwrite,
    input  logic             exmem_memread,
    input  logic [REG_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]  exmem_alu_result,
    input  logic             memwb_regwrite,
    input  logic [REG_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic [XLEN-1:0]  data_c,
    output hz_class_e        hz_c
);

    logic     rs_nz;
    logic     ex_hit;
    logic     mem_hit;
    logic     wb_hit;
    fwd_sel_e sel;

    // rd == rs with rs != 0 implies rd != 0, so x0 never matches.
    assign rs_nz   = (rs != REG_W'(REG_ZERO));
    assign ex_hit  = branch_valid && rs_nz && idex_regwrite  && (idex_rd  == rs);
    assign mem_hit = branch_valid && rs_nz && exmem_regwrite && (exmem_rd == rs);
    assign wb_hit  = branch_valid && rs_nz && memwb_regwrite && (memwb_rd == rs);

    // Forward select: younger producer wins; a load in MEM has no data yet.
    always_comb begin
        sel = FWD_RF;
        if (mem_hit && !exmem_memread) begin
            sel = FWD_EXMEM;
        end else if (wb_hit) begin
            sel = FWD_MEMWB;
        end
    end

    always_comb begin
        data_c = rf_data;
        case (sel)
            FWD_EXMEM: data_c = exmem_alu_result;
            FWD_MEMWB: data_c = wb_data;
            default:   data_c = rf_data;
        endcase
    end

    // Stall class: load in EX needs two cycles, ALU in EX or load in MEM one.
    always_comb begin
        hz_c = HZ_NONE;
        if (ex_hit && idex_memread) begin
            hz_c = HZ_TWO;
        end else if (ex_hit || (mem_hit && exmem_memread)) begin
            hz_c = HZ_ONE;
        end
    end

endmodule

// File: rtl/branch_operand_resolver.sv
// ID-stage branch operand resolver: forwards NUM_SRC operands, stalls IF/ID
// while a producer is not yet forwardable and counts stalled cycles.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   branch_valid, flush  - branch in ID needing operands; pipeline flush
//   id_rs, rf_data       - packed source addresses and register-file data
//   idex_*/exmem_*/memwb_*, exmem_alu_result, wb_data - producer state
//   branch_data          - packed resolved operands (combinational)
//   branch_stall         - hold PC and IF/ID, bubble ID/EX (combinational)
//   operands_ready       - branch_valid && !branch_stall
//   stall_cycles         - saturating count of stalled cycles
module branch_operand_resolver
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned REG_W   = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     branch_valid,
    input  logic                     flush,
    input  logic [NUM_SRC*REG_W-1:0] id_rs,
    input  logic [NUM_SRC*XLEN-1:0]  rf_data,
    input  logic                     idex_regwrite,
    input  logic                     idex_memread,
    input  logic [REG_W-1:0]         idex_rd,
    input  logic                     exmem_regwrite,
    input  logic                     exmem_memread,
    input  logic [REG_W-1:0]         exmem_rd,
    input  logic [XLEN-1:0]          exmem_alu_result,
    input  logic                     memwb_regwrite,
    input  logic [REG_W-1:0]         memwb_rd,
    input  logic [XLEN-1:0]          wb_data,
    output logic [NUM_SRC*XLEN-1:0]  branch_data,
    output logic                     branch_stall,
    output logic                     operands_ready,
    output logic [CNT_W-1:0]         stall_cycles
);

    hold_state_e       state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic              stall_c;
    hz_class_e         src_hz [NUM_SRC];
    hz_class_e         hz_worst;

    // One forwarding slice per source operand.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        branch_fwd_mux #(
            .XLEN  (XLEN),
            .REG_W (REG_W)
        ) u_fwd (
            .branch_valid     (branch_valid),
            .rs               (id_rs[i*REG_W +: REG_W]),
            .rf_data          (rf_data[i*XLEN +: XLEN]),
            .idex_regwrite    (idex_regwrite),
            .idex_memread     (idex_memread),
            .idex_rd          (idex_rd),
            .exmem_regwrite   (exmem_regwrite),
            .exmem_memread    (exmem_memread),
            .exmem_rd         (exmem_rd),
            .exmem_alu_result (exmem_alu_result),
            .memwb_regwrite   (memwb_regwrite),
            .memwb_rd         (memwb_rd),
            .wb_data          (wb_data),
            .data_c           (branch_data[i*XLEN +: XLEN]),
            .hz_c             (src_hz[i])
        );
    end

    // Worst-case hazard over all sources.
    always_comb begin
        hz_worst = HZ_NONE;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            hz_worst = hz_max(hz_worst, src_hz[i]);
        end
    end

    // Hold FSM next state and stall decision; flush overrides everything.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        stall_c    = 1'b0;
        if (flush) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hz_worst == HZ_TWO) begin
                        stall_c    = 1'b1;
                        state_d    = HOLD;
                        hold_cnt_d = HOLD_W'(1);
                    end else if (hz_worst == HZ_ONE) begin
                        // Producer moves one stage on; re-evaluate next cycle.
                        stall_c = 1'b1;
                    end
                end
                HOLD: begin
                    if (!branch_valid) begin
                        state_d    = IDLE;
                        hold_cnt_d = '0;
                    end else begin
                        stall_c    = 1'b1;
                        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                        if (hold_cnt_q <= HOLD_W'(1)) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                end
            endcase
        end
        if (rst) begin
            stall_c = 1'b0;
        end
    end

    // Saturating stall-cycle counter.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_c && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            hold_cnt_q     <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign branch_stall   = stall_c;
    assign operands_ready = branch_valid && !stall_c;
    assign stall_cycles   = stall_cycles_q;

endmodule
